// File: rtl/tpu_seq_pkg.sv
// tpu_seq_pkg: shared types and constants for the TPU command sequencer.
// Holds TPU funct codes, sequencer FSM states and datapath widths.
package tpu_seq_pkg;

  localparam int K_W    = 16;
  localparam int DATA_W = 32;
  localparam int T_W    = 16;

  localparam logic [2:0] F_NOP   = 3'd0;
  localparam logic [2:0] F_CFG   = 3'd1;
  localparam logic [2:0] F_LOAD  = 3'd2;
  localparam logic [2:0] F_READ  = 3'd3;
  localparam logic [2:0] F_CLR   = 3'd4;
  localparam logic [2:0] F_START = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_CLR,
    S_LOAD,
    S_START,
    S_WAIT,
    S_RDISS,
    S_RDWAIT,
    S_EMIT,
    S_ABORT
  } state_t;

endpackage

// File: rtl/tpu_cmd_sequencer_if.sv
// tpu_cmd_sequencer_if: job/operand/result handshakes plus TPU command port.
// master = sequencer side, slave = host and TPU side.
interface tpu_cmd_sequencer_if;
  import tpu_seq_pkg::*;

  logic              job_valid;
  logic              job_ready;
  logic [K_W-1:0]    job_k;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_last;
  logic              job_err;
  logic [2:0]        tpu_funct;
  logic [DATA_W-1:0] tpu_in0;
  logic [DATA_W-1:0] tpu_in1;
  logic [15:0]       tpu_cidx;
  logic [DATA_W-1:0] tpu_cout;

  modport master (
    input  job_valid, job_k,
    input  op_valid, op_a, op_b,
    input  res_ready,
    input  tpu_cidx, tpu_cout,
    output job_ready, op_ready,
    output res_valid, res_data, res_last,
    output job_err,
    output tpu_funct, tpu_in0, tpu_in1
  );

  modport slave (
    output job_valid, job_k,
    output op_valid, op_a, op_b,
    output res_ready,
    output tpu_cidx, tpu_cout,
    input  job_ready, op_ready,
    input  res_valid, res_data, res_last,
    input  job_err,
    input  tpu_funct, tpu_in0, tpu_in1
  );

endinterface

// File: rtl/tpu_seq_timer.sv
// tpu_seq_timer: loadable down-counter that stops at zero.
// Shared by the WAIT settle/timeout and the RDWAIT read latency.
module tpu_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/tpu_cmd_sequencer.sv
// tpu_cmd_sequencer: turns a K-beat job into TPU commands and reads back C.
// Define TPU_SEQ_PERF_EN to add the perf_cycles job-latency output.
module tpu_cmd_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int KMAX        = 1024,
  parameter int SETTLE_CYC  = 4,
  parameter int READ_LAT    = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic clk,
  input logic rst_n,
  tpu_cmd_sequencer_if.master bus
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  state_t state_q, state_d;

  logic [K_W-1:0]    k_q, k_d;
  logic [K_W-1:0]    cnt_q, cnt_d;
  logic [3:0]        elem_q, elem_d;
  logic              settle_q, settle_d;

  logic              job_ready_q;
  logic              op_ready_q;
  logic              res_valid_q;
  logic              res_last_q, res_last_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              job_err_q, job_err_d;
  logic [2:0]        funct_q, funct_d;
  logic [DATA_W-1:0] in0_q, in0_d;
  logic [DATA_W-1:0] in1_q, in1_d;

  logic              tmr_load;
  logic [T_W-1:0]    tmr_val;
  logic              tmr_expired;

  tpu_seq_timer #(.W(T_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    elem_d     = elem_q;
    settle_d   = settle_q;
    res_last_d = res_last_q;
    res_data_d = res_data_q;
    job_err_d  = 1'b0;
    funct_d    = F_NOP;
    in0_d      = in0_q;
    in1_d      = in1_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.job_valid && job_ready_q) begin
          k_d = bus.job_k;
          if (bus.job_k == '0 ||
              bus.job_k > K_W'(KMAX)) begin
            job_err_d = 1'b1;
          end else begin
            state_d = S_CFG;
          end
        end
      end
      S_CFG: begin
        funct_d = F_CFG;
        in0_d   = {{(DATA_W-K_W){1'b0}}, k_q};
        state_d = S_CLR;
      end
      S_CLR: begin
        funct_d = F_CLR;
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (bus.op_valid && op_ready_q) begin
          funct_d = F_LOAD;
          in0_d   = bus.op_a;
          in1_d   = bus.op_b;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == k_q) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        funct_d  = F_START;
        settle_d = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = T_W'(TIMEOUT_CYC - 1);
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // timer first guards the timeout, then is reused for settling
        if (!settle_q) begin
          if (bus.tpu_cidx == 16'd3) begin
            settle_d = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = T_W'(SETTLE_CYC - 1);
          end else if (tmr_expired) begin
            state_d = S_ABORT;
          end
        end else if (tmr_expired) begin
          elem_d  = '0;
          state_d = S_RDISS;
        end
      end
      S_RDISS: begin
        funct_d  = F_READ;
        in0_d    = {{(DATA_W-2){1'b0}}, elem_q[3:2]};
        in1_d    = {{(DATA_W-2){1'b0}}, elem_q[1:0]};
        tmr_load = 1'b1;
        tmr_val  = T_W'(READ_LAT - 1);
        state_d  = S_RDWAIT;
      end
      S_RDWAIT: begin
        if (tmr_expired) begin
          res_data_d = bus.tpu_cout;
          res_last_d = (elem_q == 4'd15);
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.res_ready) begin
          res_last_d = 1'b0;
          if (elem_q == 4'd15) begin
            state_d = S_IDLE;
          end else begin
            elem_d  = elem_q + 1'b1;
            state_d = S_RDISS;
          end
        end
      end
      S_ABORT: begin
        funct_d   = F_CLR;
        job_err_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      elem_q      <= '0;
      settle_q    <= 1'b0;
      job_ready_q <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      job_err_q   <= 1'b0;
      funct_q     <= F_NOP;
      in0_q       <= '0;
      in1_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      elem_q      <= elem_d;
      settle_q    <= settle_d;
      job_ready_q <= (state_d == S_IDLE);
      op_ready_q  <= (state_d == S_LOAD);
      res_valid_q <= (state_d == S_EMIT);
      res_last_q  <= res_last_d;
      res_data_q  <= res_data_d;
      job_err_q   <= job_err_d;
      funct_q     <= funct_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
    end
  end

  assign bus.job_ready = job_ready_q;
  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_last  = res_last_q;
  assign bus.res_data  = res_data_q;
  assign bus.job_err   = job_err_q;
  assign bus.tpu_funct = funct_q;
  assign bus.tpu_in0   = in0_q;
  assign bus.tpu_in1   = in1_q;

`ifdef TPU_SEQ_PERF_EN
  logic        perf_run_q;
  logic [31:0] perf_q;
  logic        perf_start;
  logic        perf_stop;

  assign perf_start = (state_q == S_IDLE) &&
                      (state_d == S_CFG);
  assign perf_stop  = (state_q == S_ABORT) ||
                      ((state_q == S_EMIT) &&
                       (state_d == S_IDLE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_run_q <= 1'b0;
      perf_q     <= '0;
    end else if (perf_start) begin
      perf_run_q <= 1'b1;
      perf_q     <= '0;
    end else if (perf_run_q) begin
      if (perf_q != '1) begin
        perf_q <= perf_q + 1'b1;
      end
      if (perf_stop) begin
        perf_run_q <= 1'b0;
      end
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// tb_tpu_cmd_sequencer: directed and randomized jobs against a TPU model.
// Expected C values come from the matrix product of the driven operands.
module tb_tpu_cmd_sequencer;
  import tpu_seq_pkg::*;

  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpu_cmd_sequencer_if tif();

`ifdef TPU_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  tpu_cmd_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif)
`ifdef TPU_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  int tests = 0;
  int failed = 0;

  logic [31:0] aq[$];
  logic [31:0] bq[$];
  logic [2:0]  trace[$];
  int          res_cnt = 0;
  int          tbase = 0;
  bit          tpu_stall = 1'b0;
  bit          directed = 1'b0;

  function automatic int lane(logic [31:0] w, int i);
    byte b;
    b = byte'(w >> (24 - 8 * i));
    return int'(b);
  endfunction

  // C[r][c] = sum over beats of A[r][k] * B[k][c]
  function automatic int ref_c(int r, int c);
    int s = 0;
    foreach (aq[k]) s += lane(aq[k], r) * lane(bq[k], c);
    return s;
  endfunction

  // behavioural 4x4 TPU
  int cm[4][4];
  int dly = 0;
  bit busy = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      tif.tpu_cidx <= 16'd0;
      tif.tpu_cout <= 32'd0;
      busy = 1'b0;
    end else begin
      if (busy) begin
        if (dly == 0) begin
          tif.tpu_cidx <= 16'd3;
          busy = 1'b0;
        end else dly--;
      end
      case (tif.tpu_funct)
        3'd4: begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) cm[r][c] = 0;
          tif.tpu_cidx <= 16'd0;
          busy = 1'b0;
        end
        3'd2: begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              cm[r][c] += lane(tif.tpu_in0, r) * lane(tif.tpu_in1, c);
        end
        3'd6: if (!tpu_stall) begin
          busy = 1'b1;
          dly = 5;
        end
        3'd3: tif.tpu_cout <= cm[tif.tpu_in0[1:0]][tif.tpu_in1[1:0]];
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tif.tpu_funct != 3'd0) trace.push_back(tif.tpu_funct);
      if (tif.res_valid) res_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int k);
    int n = 0;
    tbase = trace.size();
    while (!tif.job_ready && n < 100) begin tick; n++; end
    chk("job_ready_wait", tif.job_ready, 1);
    tif.job_valid = 1'b1;
    tif.job_k = 16'(k);
    tick;
    tif.job_valid = 1'b0;
    chk("job_ready_drop", tif.job_ready, 0);
    tick;
    chk("cfg_funct", tif.tpu_funct, 1);
    chk("cfg_in0", tif.tpu_in0, k);
    tick;
    chk("clr_funct", tif.tpu_funct, 4);
  endtask

  task automatic load_beats(input int k, input bit gap, input int nmax);
    int n;
    aq.delete();
    bq.delete();
    for (int i = 0; i < k; i++) begin
      aq.push_back(directed ? (32'h01000000 >> (8 * i)) : $urandom);
      bq.push_back(directed ? 32'h01020304 : $urandom);
    end
    for (int i = 0; i < nmax; i++) begin
      tif.op_valid = 1'b1;
      tif.op_a = aq[i];
      tif.op_b = bq[i];
      n = 0;
      while (!tif.op_ready && n < 50) begin tick; n++; end
      chk("op_ready_wait", tif.op_ready, 1);
      tick;
      chk($sformatf("beat%0d_funct", i), tif.tpu_funct, 2);
      chk($sformatf("beat%0d_in0", i), tif.tpu_in0, aq[i]);
      chk($sformatf("beat%0d_in1", i), tif.tpu_in1, bq[i]);
      tif.op_valid = 1'b0;
      if (i == k - 1) begin
        chk("op_ready_after_last", tif.op_ready, 0);
        tick;
        chk("start_after_last", tif.tpu_funct, 6);
      end else if (gap) begin
        tick;
        chk("gap_nop", tif.tpu_funct, 0);
      end
    end
    tif.op_valid = 1'b0;
  endtask

  task automatic read_results(input int stall_idx);
    int n;
    logic [31:0] d;
    int tsz;
    tif.res_ready = 1'b0;
    for (int e = 0; e < 16; e++) begin
      n = 0;
      while (!tif.res_valid && n < 300) begin tick; n++; end
      chk("res_valid_wait", tif.res_valid, 1);
      chk($sformatf("res_data[%0d]", e), tif.res_data, ref_c(e / 4, e % 4));
      chk($sformatf("res_last[%0d]", e), tif.res_last, (e == 15));
      if (e == stall_idx) begin
        d = tif.res_data;
        tsz = trace.size();
        repeat (20) begin
          tick;
          chk("stall_valid", tif.res_valid, 1);
          chk("stall_data", tif.res_data, d);
          chk("stall_no_read", trace.size(), tsz);
        end
      end
      tif.res_ready = 1'b1;
      tick;
      tif.res_ready = 1'b0;
      chk("res_valid_drop", tif.res_valid, 0);
    end
  endtask

  task automatic check_trace(input int k, input bit aborted);
    logic [2:0] ex[$];
    ex.push_back(3'd1);
    ex.push_back(3'd4);
    repeat (k) ex.push_back(3'd2);
    ex.push_back(3'd6);
    if (aborted) ex.push_back(3'd4);
    else repeat (16) ex.push_back(3'd3);
    chk("trace_len", trace.size() - tbase, ex.size());
    foreach (ex[i])
      if (tbase + i < trace.size())
        chk($sformatf("trace[%0d]", i), trace[tbase + i], ex[i]);
  endtask

  task automatic reject(input int k);
    int tsz;
    tsz = trace.size();
    tif.job_valid = 1'b1;
    tif.job_k = 16'(k);
    tick;
    tif.job_valid = 1'b0;
    chk("rej_err", tif.job_err, 1);
    chk("rej_funct", tif.tpu_funct, 0);
    chk("rej_ready", tif.job_ready, 1);
    tick;
    chk("rej_err_pulse", tif.job_err, 0);
    repeat (3) tick;
    chk("rej_no_cmd", trace.size(), tsz);
  endtask

  task automatic check_reset_outputs;
    chk("rst_job_ready", tif.job_ready, 0);
    chk("rst_op_ready", tif.op_ready, 0);
    chk("rst_res_valid", tif.res_valid, 0);
    chk("rst_res_last", tif.res_last, 0);
    chk("rst_res_data", tif.res_data, 0);
    chk("rst_job_err", tif.job_err, 0);
    chk("rst_funct", tif.tpu_funct, 0);
    chk("rst_in0", tif.tpu_in0, 0);
    chk("rst_in1", tif.tpu_in1, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, r0;
    tif.job_valid = 1'b0;
    tif.job_k = '0;
    tif.op_valid = 1'b0;
    tif.op_a = '0;
    tif.op_b = '0;
    tif.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick;
    check_reset_outputs();
    rst_n = 1'b1;
    tick;
    chk("ready_after_reset", tif.job_ready, 1);

    // identity A, constant B rows
    directed = 1'b1;
    start_job(4);
    load_beats(4, 1'b0, 4);
    read_results(-1);
    tick;
    check_trace(4, 1'b0);
    directed = 1'b0;

    reject(0);
    reject(1025);

    // gapped operands plus result backpressure on element 5
    start_job(8);
    load_beats(8, 1'b1, 8);
    read_results(5);
    tick;
    check_trace(8, 1'b0);

    // stuck TPU
    tpu_stall = 1'b1;
    r0 = res_cnt;
    start_job(2);
    load_beats(2, 1'b0, 2);
    n = 0;
    while (!tif.job_err && n < TIMEOUT + 50) begin tick; n++; end
    chk("timeout_err", tif.job_err, 1);
    chk("timeout_funct", tif.tpu_funct, 4);
    chk("timeout_window", (n >= TIMEOUT && n <= TIMEOUT + 4), 1);
    tick;
    chk("timeout_err_pulse", tif.job_err, 0);
    chk("timeout_ready", tif.job_ready, 1);
    chk("timeout_no_res", res_cnt, r0);
    check_trace(2, 1'b1);
    tpu_stall = 1'b0;

    repeat (3) begin
      k = $urandom_range(1, 12);
      start_job(k);
      load_beats(k, 1'($urandom_range(0, 1)), k);
      read_results(-1);
      tick;
      check_trace(k, 1'b0);
    end

    // reset while the third of eight beats is offered
    start_job(8);
    load_beats(8, 1'b0, 2);
    tif.op_valid = 1'b1;
    tif.op_a = aq[2];
    tif.op_b = bq[2];
    rst_n = 1'b0;
    tick;
    check_reset_outputs();
    tif.op_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("ready_after_midreset", tif.job_ready, 1);
    start_job(2);
    load_beats(2, 1'b0, 2);
    read_results(-1);
    tick;
    check_trace(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tpu_cmd_sequencer.md
Name: tpu_cmd_sequencer

Overview:
- Host-side initiator for the 4x4 systolic TPU command port. It takes one job descriptor (K) and K operand beats, and turns them into the TPU funct/input0/input1 command sequence.
- After compute, it reads the 16 C results back one at a time and streams them out in row-major order.
- Sits between the CFU op decoder and the TPU, so software no longer hand-issues each funct.

Parameters:
- KMAX, 1024, largest accepted K (beats per job)
- SETTLE_CYC, 4, cycles waited after tpu_cidx reaches 3 before readback starts
- READ_LAT, 2, cycles from issuing funct 3 to sampling tpu_cout
- TIMEOUT_CYC, 4096, maximum WAIT-state cycles before the job aborts

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- job_valid  in  1  job descriptor valid
- job_ready  out  1  sequencer idle and accepting a job
- job_k  in  16  inner dimension K
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accepted
- op_a  in  32  four packed 8-bit A values, row 0 in [31:24]
- op_b  in  32  four packed 8-bit B values, column 0 in [31:24]
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  32  signed C element
- res_last  out  1  marks element 15
- job_err  out  1  one-cycle pulse: job rejected or timed out
- tpu_funct  out  3  TPU command code
- tpu_in0  out  32  TPU input0
- tpu_in1  out  32  TPU input1
- tpu_cidx  in  16  TPU C-buffer write index
- tpu_cout  in  32  TPU C readback data

Behaviour:
- Reset values: job_ready=0 during reset and 1 in the first IDLE cycle after it; op_ready=0, res_valid=0, res_last=0, res_data=0, job_err=0, tpu_funct=0, tpu_in0=0, tpu_in1=0. Reset clears all counters.
- tpu_funct=0 is NOP. Every command is held for exactly one cycle, then tpu_funct returns to 0.
- All outputs are registered.
- FSM states: IDLE, CFG, CLR, LOAD, START, WAIT, RDISS, RDWAIT, EMIT, ABORT.
- IDLE: job_ready=1. On job_valid&&job_ready, latch job_k.
  - job_k==0 or job_k>KMAX: pulse job_err, stay in IDLE, issue no TPU commands.
  - Otherwise go to CFG.
- CFG: funct=1, in0=K (zero-extended). Go to CLR.
- CLR: funct=4. Go to LOAD; load counter=0.
- LOAD: op_ready=1.
  - Each op_valid&&op_ready beat issues funct=2, in0=op_a, in1=op_b, and increments the load counter.
  - A cycle with no beat issues funct=0.
  - After beat K is accepted, deassert op_ready in the same cycle and go to START.
  - At most one beat per cycle.
- START: funct=6. Go to WAIT; clear the timer.
- WAIT:
  - Once tpu_cidx==3, count SETTLE_CYC further cycles, then go to RDISS with elem=0.
  - If the timer reaches TIMEOUT_CYC first, go to ABORT.
- RDISS: funct=3, in0=elem[3:2] (row), in1=elem[1:0] (column). Go to RDWAIT.
- RDWAIT: hold in0/in1 and funct=0 for READ_LAT cycles. Then capture tpu_cout into res_data and go to EMIT.
- EMIT: res_valid=1, res_last=(elem==15).
  - res_data and res_last stay stable until res_ready.
  - On the handshake, res_valid drops the next cycle. If elem==15 go to IDLE; else elem+1 and go to RDISS.
  - Backpressure is unbounded: no timeout in EMIT.
- ABORT: funct=4, pulse job_err, go to IDLE. Discard any remaining results; res_valid is never asserted.
- job_valid while busy is ignored because job_ready=0 outside IDLE.
- op_valid outside LOAD is ignored because op_ready=0.
- Reset mid-job returns to IDLE with all outputs at reset values; the TPU is not sent a clean-up command.
- Throughput: minimum 1+1+K+1+(tpu_cidx latency)+SETTLE_CYC+16*(2+READ_LAT) cycles per job.

Optional Feature:
- TPU_SEQ_PERF_EN defined: adds output perf_cycles (32 bits).
  - Counts cycles from job acceptance to the res_last handshake.
  - Holds its value until the next job is accepted; saturates at all-ones; reset value 0.
  - Timed-out jobs leave it at the count reached at abort.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package tpu_seq_pkg holds:
  - funct constants: NOP=0, CFG=1, LOAD=2, READ=3, CLR=4, START=6
  - the state enum
  - widths: K_W=16, DATA_W=32
- One sub-module, tpu_seq_timer: a loadable down-counter shared by the WAIT settle/timeout and RDWAIT latency, with load/value/expired interface.

Test Plan:
- K=4, A=identity packing (0x01000000, 0x00010000, 0x00000100, 0x00000001), B words 0x01020304 x4 → TPU model yields C rows; bench sees 16 res beats, res_last only on beat 16, funct trace 1,4,2,2,2,2,6,then 3 x16.
- job_k=0 → job_err pulse one cycle after handshake, tpu_funct stays 0, job_ready remains 1.
- K=8 with op_valid toggling every other cycle → exactly 8 funct=2 commands, funct=0 in gap cycles, START issued one cycle after the 8th beat.
- res_ready held low 20 cycles on element 5 → res_data and res_valid stable, no funct=3 issued until release.
- TPU model never advances tpu_cidx → job_err after TIMEOUT_CYC, funct=4 issued, no res_valid, next job accepted normally.
- rst_n low for 1 cycle during LOAD (beat 3 of 8) → all outputs at reset values, a new K=2 job completes correctly.
